// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package timer_pkg;

  // Timer control states; the encoding 2'd3 is unused and recovers to idle.
  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_DONE = 2'd2
  } tmr_state_e;

  // Default count width.
  localparam int TMR_WIDTH_DEF = 4;

endpackage : timer_pkg

// File: rtl/countdown_timer.sv
// Loadable synchronous down counter with a start/ready handshake and a
// one-cycle done pulse. Every flop is on clk; rst is synchronous, active-low.
// Optional build macro TIMER_AUTO_RELOAD_EN enables periodic mode: on done the
// counter reloads the last accepted load value and keeps running until abort.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TMR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  tmr_state_e       state, state_d;
  logic [WIDTH-1:0] q_d;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload, reload_d;
`endif

  // Next state and next datapath values, decided together per state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state;
    q_d     = q;
`ifdef TIMER_AUTO_RELOAD_EN
    reload_d = reload;
`endif
    case (state)
      TMR_IDLE: begin
        // abort wins over a simultaneous start.
        if (start && !abort) begin
          q_d = load_val;
`ifdef TIMER_AUTO_RELOAD_EN
          reload_d = load_val;
`endif
          state_d = (load_val == '0) ? TMR_DONE : TMR_RUN;
        end
      end
      TMR_RUN: begin
        if (abort) begin
          // Cancelled counts keep q visible and never pulse done.
          state_d = TMR_IDLE;
        end else if (en) begin
          // Compare with <= so a stray zero can never wrap to all-ones.
          if (q <= ONE) begin
            q_d     = '0;
            state_d = TMR_DONE;
          end else begin
            q_d = q - ONE;
          end
        end
      end
      TMR_DONE: begin
`ifdef TIMER_AUTO_RELOAD_EN
        if (!abort && (reload != '0)) begin
          q_d     = reload;
          state_d = TMR_RUN;
        end else begin
          state_d = TMR_IDLE;
        end
`else
        state_d = TMR_IDLE;
`endif
      end
      default: begin
        // Unreachable encoding: recover to a clean idle.
        q_d     = '0;
        state_d = TMR_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      state <= TMR_IDLE;
      q     <= '0;
`ifdef TIMER_AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      state <= state_d;
      q     <= q_d;
`ifdef TIMER_AUTO_RELOAD_EN
      reload <= reload_d;
`endif
    end
  end

  // Handshake and status outputs decoded from the registered state only.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      TMR_IDLE: ready = 1'b1;
      TMR_RUN:  busy  = 1'b1;
      TMR_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH=4).
// Inputs change 1 ns after posedge; outputs are checked at that same point.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] load_val;
  logic         en;
  logic         abort;
  logic [W-1:0] q;
  logic         ready;
  logic         busy;
  logic         done;

  int tests_run    = 0;
  int tests_failed = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .q        (q),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic [W-1:0] eq,
                              input logic er, input logic eb, input logic ed);
    check({tag, ".q"},     32'(q),     32'(eq));
    check({tag, ".ready"}, 32'(ready), 32'(er));
    check({tag, ".busy"},  32'(busy),  32'(eb));
    check({tag, ".done"},  32'(done),  32'(ed));
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pause_q [9];
    logic         pause_en [9];
    int           cycles;
    bit           seen;

    pause_en = '{1, 0, 0, 1, 0, 1, 1, 1, 1};
    pause_q  = '{5, 5, 5, 4, 4, 3, 2, 1, 0};

    rst = 1'b0; start = 1'b0; load_val = '0; en = 1'b0; abort = 1'b0;

    // Power-on reset.
    step(); step();
    check_status("reset", 4'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;

    // Reset mid-count at q=9.
    start = 1'b1; load_val = 4'd10; en = 1'b1;
    step();
    start = 1'b0;
    check_status("rstmid.load", 4'd10, 1'b0, 1'b1, 1'b0);
    step();
    check("rstmid.q9", 32'(q), 32'd9);
    rst = 1'b0;
    step();
    check_status("rstmid.c1", 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    check_status("rstmid.c2", 4'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check_status("rstmid.after", 4'd0, 1'b1, 1'b0, 1'b0);

    // Plain count from 5 with en held high.
    start = 1'b1; load_val = 4'd5; en = 1'b1;
    step();
    start = 1'b0;
    check_status("cnt5.E", 4'd5, 1'b0, 1'b1, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      step();
      check_status($sformatf("cnt5.q%0d", k), W'(k), 1'b0, 1'b1, 1'b0);
    end
    step();
    check_status("cnt5.done", 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    check_status("cnt5.ready", 4'd0, 1'b1, 1'b0, 1'b0);

    // Pause: en pattern 1,0,0,1,0,1,1,1,1 from load 6.
    start = 1'b1; load_val = 4'd6;
    step();
    start = 1'b0;
    check("pause.load", 32'(q), 32'd6);
    for (int i = 0; i < 9; i++) begin
      en = pause_en[i];
      step();
      check($sformatf("pause.q%0d", i), 32'(q), 32'(pause_q[i]));
      check($sformatf("pause.done%0d", i), 32'(done), (i == 8) ? 32'd1 : 32'd0);
    end
    en = 1'b1;
    step();
    check("pause.idle", 32'(ready), 32'd1);

    // Abort at q=3, then abort together with start in idle.
    start = 1'b1; load_val = 4'd5;
    step();
    start = 1'b0;
    step(); step();
    check("abort.q3", 32'(q), 32'd3);
    abort = 1'b1;
    step();
    check_status("abort.idle", 4'd3, 1'b1, 1'b0, 1'b0);
    start = 1'b1; load_val = 4'd7;
    step();
    check_status("abort.start", 4'd3, 1'b1, 1'b0, 1'b0);
    start = 1'b0; abort = 1'b0;

    // Zero load goes straight to done.
    start = 1'b1; load_val = 4'd0;
    step();
    start = 1'b0;
    check_status("zero.done", 4'd0, 1'b0, 1'b1, 1'b1);
    step();
    check_status("zero.idle", 4'd0, 1'b1, 1'b0, 1'b0);

    // Start while busy is ignored.
    start = 1'b1; load_val = 4'd4;
    step();
    check("busy.load", 32'(q), 32'd4);
    load_val = 4'd9;
    step();
    check("busy.ign1", 32'(q), 32'd3);
    step();
    check_status("busy.ign2", 4'd2, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    step(); step();
    check_status("busy.done", 4'd0, 1'b0, 1'b1, 1'b1);
    step();

`ifdef TIMER_AUTO_RELOAD_EN
    // Periodic mode: load 3 gives done on every fourth edge.
    start = 1'b1; load_val = 4'd3;
    step();
    start = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (done) cycles++;
      check($sformatf("auto.done%0d", i), 32'(done), (i % 4 == 3) ? 32'd1 : 32'd0);
      check($sformatf("auto.ready%0d", i), 32'(ready), 32'd0);
    end
    check("auto.pulses", 32'(cycles), 32'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("auto.abort", 32'(ready), 32'd1);
`endif

    // Maximum load: done after exactly 15 enabled cycles.
    start = 1'b1; load_val = 4'd15;
    step();
    start = 1'b0;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      step();
      cycles++;
      seen = done;
    end
    check("max.seen", 32'(seen), 32'd1);
    check("max.cycles", 32'(cycles), 32'd15);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_status("max.idle", 4'd0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_countdown_timer
